// File: rtl/soc_router_pkg.sv
// Shared types and defaults for the CPU request router.
package soc_router_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} rtr_state_t;

  localparam int          RTR_MAX_TGT      = 8;
  localparam logic [31:0] RTR_ERR_RDAT_DEF = 32'hDEAD_BEEF;

  // Timeout counter width; stays at least 1 bit when the timeout is disabled.
  function automatic int rtr_cnt_w(input int cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/soc_router_decode.sv
// Combinational base/mask address decode; the lowest matching index wins.
module soc_router_decode #(
  parameter int                    NUM_TGT  = 4,
  parameter logic [NUM_TGT*32-1:0] TGT_BASE = '0,
  parameter logic [NUM_TGT*32-1:0] TGT_MASK = '0
) (
  input  logic [31:2]        i_addr,
  output logic [NUM_TGT-1:0] o_hit,
  output logic               o_miss
);

  logic [31:0] w_baddr;
  assign w_baddr = {i_addr, 2'b00};

  always_comb begin
    o_hit  = '0;
    o_miss = 1'b1;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (o_miss && ((w_baddr & TGT_MASK[32*i +: 32]) == TGT_BASE[32*i +: 32])) begin
        o_hit[i] = 1'b1;
        o_miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/soc_cpu_router.sv
// Registered CPU-to-slave request router with unmapped/timeout bus errors
// and a sticky first-error capture for firmware.
module soc_cpu_router
  import soc_router_pkg::*;
#(
  parameter int                    NUM_TGT     = 4,
  parameter logic [NUM_TGT*32-1:0] TGT_BASE    = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_TGT*32-1:0] TGT_MASK    = {32'hC000_0000, 32'hE000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter int                    TIMEOUT_CYC = 1024,
  parameter logic [31:0]           ERR_RDAT    = RTR_ERR_RDAT_DEF
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  cpu_vld,
  output logic                  cpu_rdy,
  input  logic [31:2]           cpu_addr,
  input  logic [3:0]            cpu_we,
  input  logic [31:0]           cpu_wdat,
  output logic [31:0]           cpu_rdat,
  output logic                  cpu_err,
  output logic [NUM_TGT-1:0]    tgt_vld,
  input  logic [NUM_TGT-1:0]    tgt_rdy,
  output logic [31:2]           tgt_addr,
  output logic [3:0]            tgt_we,
  output logic [31:0]           tgt_wdat,
  input  logic [NUM_TGT*32-1:0] tgt_rdat,
  output logic                  err_sticky,
  output logic [31:2]           err_addr,
  output logic                  err_timeout,
  input  logic                  err_clr
);

  localparam int CW = rtr_cnt_w(TIMEOUT_CYC);
  localparam int SW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  rtr_state_t        r_state, w_nxt;
  logic [SW-1:0]     r_sel, w_sel;
  logic [CW-1:0]     r_cnt;
  logic [31:2]       r_addr;
  logic [3:0]        r_we;
  logic [31:0]       r_wdat, r_rdat;
  logic              r_err, r_sticky, r_eto;
  logic [31:2]       r_eaddr;
  logic [NUM_TGT-1:0] w_hit;
  logic              w_miss, w_rdy_sel, w_tmo, w_err_ev;
  logic [31:0]       w_rdat_sel;

  soc_router_decode #(
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_dec (
    .i_addr (cpu_addr),
    .o_hit  (w_hit),
    .o_miss (w_miss)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_TGT; i++)
      if (w_hit[i]) w_sel = SW'(i);
  end

  assign w_rdy_sel  = tgt_rdy[r_sel];
  assign w_rdat_sel = tgt_rdat[32*r_sel +: 32];
  assign w_tmo      = (TIMEOUT_CYC > 0) && (r_cnt == TMO_LAST);

  always_comb begin
    w_nxt    = r_state;
    w_err_ev = 1'b0;
    case (r_state)
      IDLE: if (cpu_vld) begin
        w_nxt    = w_miss ? RESP : ACTIVE;
        w_err_ev = w_miss;
      end
      // A ready in the last allowed cycle still counts as a normal completion.
      ACTIVE: if (w_rdy_sel || w_tmo) begin
        w_nxt    = RESP;
        w_err_ev = !w_rdy_sel;
      end
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_we     <= '0;
      r_wdat   <= '0;
      r_rdat   <= '0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_eaddr  <= '0;
      r_eto    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        IDLE: if (cpu_vld) begin
          r_addr <= cpu_addr;
          r_we   <= cpu_we;
          r_wdat <= cpu_wdat;
          r_sel  <= w_sel;
          r_cnt  <= '0;
          r_err  <= w_miss;
          if (w_miss) r_rdat <= ERR_RDAT;
        end
        ACTIVE: begin
          if (w_rdy_sel) begin
            r_rdat <= w_rdat_sel;
            r_err  <= 1'b0;
          end else if (w_tmo) begin
            r_rdat <= ERR_RDAT;
            r_err  <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
      // A new error beats a coincident clear.
      if (w_err_ev && (!r_sticky || err_clr)) begin
        r_sticky <= 1'b1;
        r_eaddr  <= (r_state == IDLE) ? cpu_addr : r_addr;
        r_eto    <= (r_state == ACTIVE);
      end else if (err_clr) begin
        r_sticky <= 1'b0;
        r_eaddr  <= '0;
        r_eto    <= 1'b0;
      end
    end
  end

  assign tgt_vld     = (r_state == ACTIVE) ? (NUM_TGT'(1) << r_sel) : '0;
  assign cpu_rdy     = (r_state == RESP);
  assign cpu_err     = cpu_rdy & r_err;
  assign cpu_rdat    = r_rdat;
  assign tgt_addr    = r_addr;
  assign tgt_we      = r_we;
  assign tgt_wdat    = r_wdat;
  assign err_sticky  = r_sticky;
  assign err_addr    = r_eaddr;
  assign err_timeout = r_eto;

endmodule

// File: doc/soc_cpu_router.md
# soc_cpu_router

Parametrised successor to the single-split CPU decode: a registered request router between the CPU native memory port (valid/ready, word address, byte strobes) and `NUM_TGT` slave ports (IMEM, DMEM, CSR, SDRAM, ...), each selected by a base/mask pair. It adds behaviour the plain decode lacks:
- a bus-error response for unmapped addresses;
- a per-transaction timeout that releases a hung slave;
- sticky error capture for firmware.

It sits between the CPU core and `soc_fabric`/`imem`, inside the CPU wrapper.

## Interface
- `NUM_TGT`, 4: number of slave ports (1..8).
- `TGT_BASE`, {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}: `[NUM_TGT-1:0][31:0]`; index `i` at bits `[32*i+31:32*i]`.
- `TGT_MASK`, {32'hC000_0000, 32'hE000_0000, 32'hF000_0000, 32'hF000_0000}: a hit on target `i` is `(addr & mask) == base`.
- `TIMEOUT_CYC`, 1024: ACTIVE cycles before abort; 0 disables the timeout.
- `ERR_RDAT`, 32'hDEAD_BEEF: read data returned on error.
- `clk` in 1: single clock.
- `arst` in 1: asynchronous, active-high reset.
- `cpu_vld` in 1: CPU request; held until `cpu_rdy`.
- `cpu_rdy` out 1: one-cycle completion pulse.
- `cpu_addr` in [31:2]: word address.
- `cpu_we` in 4: byte strobes; 0 means read.
- `cpu_wdat` in 32: write data.
- `cpu_rdat` out 32: read data, valid with `cpu_rdy`.
- `cpu_err` out 1: error flag, valid with `cpu_rdy`.
- `tgt_vld` out NUM_TGT: one-hot slave request.
- `tgt_rdy` in NUM_TGT: slave completion.
- `tgt_addr` out [31:2]: shared latched address.
- `tgt_we` out 4: shared latched strobes.
- `tgt_wdat` out 32: shared latched write data.
- `tgt_rdat` in NUM_TGT*32: slave read data; slot `i` at `[32*i+31:32*i]`.
- `err_sticky` out 1: error has occurred since the last clear.
- `err_addr` out [31:2]: address of the first error since the last clear.
- `err_timeout` out 1: the first error was a timeout (0 = unmapped).
- `err_clr` in 1: single-cycle clear of the error capture.

## Operation
- The FSM has three states: IDLE, ACTIVE, RESP. Reset state is IDLE.
- **IDLE**
  - On `cpu_vld`, latch address, strobes and write data, then decode.
  - If several targets hit, the lowest index wins.
  - If a target hits, go to ACTIVE with `sel` = that index, and clear the timeout counter.
  - If no target hits, go to RESP with error flagged as unmapped.
- **ACTIVE**
  - `tgt_vld[sel]`=1 and all other `tgt_vld` bits are 0. `tgt_*` outputs stay stable.
  - On `tgt_rdy[sel]`: register `tgt_rdat[sel]` into `cpu_rdat`, then go to RESP with no error.
  - `tgt_rdy` bits other than `sel` are ignored.
  - If the counter reaches `TIMEOUT_CYC`-1 without `tgt_rdy[sel]`, go to RESP with error flagged as timeout, and drop `tgt_vld`.
  - `tgt_rdy[sel]` arriving in that same cycle wins: normal completion.
- **RESP**
  - `cpu_rdy`=1 for exactly one cycle, then return to IDLE.
  - On error: `cpu_err`=1, `cpu_rdat`=`ERR_RDAT`; a write is discarded.
  - On success: `cpu_err`=0.
  - `cpu_vld` sampled in RESP is ignored; the CPU drops it after `cpu_rdy`.
- **Error capture**
  - On entry to RESP with an error while `err_sticky`=0: set `err_sticky`, load `err_addr`, set `err_timeout`.
  - While `err_sticky`=1, later errors do not overwrite the capture.
  - `err_clr` clears all three. If it coincides with a new error, the new error is recorded (set wins).
- **Counter width:** `$clog2(TIMEOUT_CYC+1)`; it saturates and never wraps.

## Timing
- **Reset values:** `cpu_rdy`, `cpu_err`, `tgt_vld`, `err_sticky`, `err_timeout` = 0; `cpu_rdat`, `tgt_addr`, `tgt_we`, `tgt_wdat`, `err_addr` = 0.
- **Success latency**, with `cpu_vld` rising at cycle 0 in IDLE:
  - `tgt_vld` at cycle 1;
  - the slave answers at cycle 1+k;
  - `cpu_rdy` at cycle 2+k.
  - Minimum 2 cycles; throughput is one transaction per 3+k cycles.
- **Unmapped:** `cpu_rdy`+`cpu_err` at cycle 1.
- **Timeout:** `tgt_vld` is high for exactly `TIMEOUT_CYC` cycles (1..TIMEOUT_CYC); `cpu_rdy`+`cpu_err` at cycle `TIMEOUT_CYC`+1.
- **Slave protocol:** the slave sees `tgt_vld` held until its `tgt_rdy`, the timeout, or reset. `tgt_vld` drops in the cycle after `tgt_rdy`.
- **Reset mid-transaction:** outputs clear asynchronously and the transaction is lost. No partial response is given.

## Structure
- Package `soc_router_pkg`:
  - state enum `rtr_state_t` {IDLE, ACTIVE, RESP};
  - `RTR_MAX_TGT`=8;
  - `RTR_ERR_RDAT_DEF`.
- Sub-module `soc_router_decode`: purely combinational.
  - Input: address, plus `TGT_BASE`/`TGT_MASK` as parameters.
  - Output: one-hot hit vector with priority applied, plus a `miss` flag.
- The FSM, latches, counter and error capture live in `soc_cpu_router`.

## Test plan
- Read `0x1000_0010`, slave 1 answers 3 cycles after `tgt_vld` with `32'h1234_5678` → `tgt_vld`=4'b0010, `cpu_rdat`=`32'h1234_5678`, `cpu_rdy` 5 cycles after `cpu_vld`, `cpu_err`=0.
- Write `cpu_we`=4'b0011 to `0x2000_0004`, data `32'hA5A5_0000`, slave answers immediately → `tgt_we`/`tgt_wdat` match, `cpu_rdy` at cycle 2.
- Read `0x8000_0000` (unmapped) → `cpu_rdy`+`cpu_err` at cycle 1, `cpu_rdat`=`32'hDEAD_BEEF`, `err_sticky`=1, `err_addr`=`30'h2000_0000`, `err_timeout`=0, no `tgt_vld`.
- `TIMEOUT_CYC`=8, slave 3 never ready → `tgt_vld[3]` high for exactly 8 cycles, `cpu_err` at cycle 9, `err_timeout`=1; a second error leaves the capture unchanged.
- `err_clr` in the same cycle as a new unmapped error → `err_sticky` stays 1 with the new address; overlapping bases (target 2 base `0x1000_0000`, mask `0xF000_0000`) → target 1 selected.
- Assert `arst` while in ACTIVE → `tgt_vld`=0 immediately; after release, the next request completes normally.
